// File: rtl/mole_tally_bcd_if.sv
// Bundles the controls, per-mole status inputs and BCD tally outputs of mole_tally_bcd.
// The master side is the game/sequencer. The slave side is the tally block.
interface mole_tally_bcd_if #(
  parameter int NUM_MOLES = 8,
  parameter int DIGITS    = 4
);
  logic                            clear;
  logic                            enable;
  logic [NUM_MOLES-1:0]            control;
  logic [NUM_MOLES-1:0]            hiding;
  logic [NUM_MOLES-1:0]            rise;
  logic [NUM_MOLES*DIGITS*4-1:0]   moleScore;
  logic [NUM_MOLES*DIGITS*4-1:0]   moleRise;
  logic [DIGITS*4-1:0]             totalScore;
  logic [DIGITS*4-1:0]             totalRise;
  logic                            scoreOvf;
  logic                            riseOvf;

  modport master (
    output clear, enable, control, hiding, rise,
    input  moleScore, moleRise, totalScore, totalRise, scoreOvf, riseOvf
  );

  modport slave (
    input  clear, enable, control, hiding, rise,
    output moleScore, moleRise, totalScore, totalRise, scoreOvf, riseOvf
  );
endinterface

// File: rtl/mole_tally_bcd.sv
// Per-mole and total BCD tallies of hit and rise events.
// An event is the rising edge of (control & hiding) or of (control & rise).
// The totals add the per-cycle event popcount directly. They do not depend on the per-mole counters.
module mole_tally_bcd #(
  parameter int NUM_MOLES = 8,
  parameter int DIGITS    = 4,
  parameter bit SATURATE  = 1'b1
) (
  input logic             clock,
  input logic             reset,
  mole_tally_bcd_if.slave bus
);
  localparam int W = DIGITS * 4;
  localparam logic [W-1:0] MAX_VAL = {DIGITS{4'h9}};

  logic [NUM_MOLES-1:0]   hit_cond, rise_cond;
  logic [NUM_MOLES-1:0]   hit_prev, rise_prev;
  logic [NUM_MOLES-1:0]   hit_ev, rise_ev;

  logic [NUM_MOLES*W-1:0] mole_score_q, mole_score_d;
  logic [NUM_MOLES*W-1:0] mole_rise_q, mole_rise_d;
  logic [W-1:0]           total_score_q, total_score_d;
  logic [W-1:0]           total_rise_q, total_rise_d;
  logic                   score_ovf_q, score_ovf_d;
  logic                   rise_ovf_q, rise_ovf_d;

  // NUM_MOLES is at most 9, so the count always fits one BCD digit.
  function automatic logic [3:0] popcount(input logic [NUM_MOLES-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NUM_MOLES; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Adds a single BCD digit into the least significant digit and ripples the carry upward.
  // Bit W of the result is the carry out of the top digit.
  function automatic logic [W:0] bcd_add(input logic [W-1:0] val, input logic [3:0] inc);
    logic [W-1:0] sum;
    logic         c;
    logic [4:0]   d;
    sum = '0;
    c   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      d = {1'b0, val[i*4 +: 4]} + {4'b0000, c};
      if (i == 0) d = d + {1'b0, inc};
      if (d > 5'd9) begin
        d = d - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      sum[i*4 +: 4] = d[3:0];
    end
    return {c, sum};
  endfunction

  // When the add overflows, the result is clamped to all 9s in saturate mode.
  // In wrap mode the carry is simply dropped, which gives the sum modulo 10^DIGITS.
  function automatic logic [W:0] bcd_step(input logic [W-1:0] val, input logic [3:0] inc);
    logic [W:0] raw;
    raw = bcd_add(val, inc);
    if (raw[W] && SATURATE) raw[W-1:0] = MAX_VAL;
    return raw;
  endfunction

  assign hit_cond  = bus.control & bus.hiding;
  assign rise_cond = bus.control & bus.rise;
  assign hit_ev    = hit_cond & ~hit_prev;
  assign rise_ev   = rise_cond & ~rise_prev;

  // Edge-detect history runs every cycle, so conditions that are high while disabled or cleared are not queued.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_prev  <= '1;
      rise_prev <= '1;
    end else begin
      hit_prev  <= hit_cond;
      rise_prev <= rise_cond;
    end
  end

  // Next-state for counters and sticky flags. Clear takes priority over enable.
  always_comb begin
    logic [W:0] step;
    step          = '0;
    mole_score_d  = mole_score_q;
    mole_rise_d   = mole_rise_q;
    total_score_d = total_score_q;
    total_rise_d  = total_rise_q;
    score_ovf_d   = score_ovf_q;
    rise_ovf_d    = rise_ovf_q;
    if (bus.clear) begin
      mole_score_d  = '0;
      mole_rise_d   = '0;
      total_score_d = '0;
      total_rise_d  = '0;
      score_ovf_d   = 1'b0;
      rise_ovf_d    = 1'b0;
    end else if (bus.enable) begin
      for (int i = 0; i < NUM_MOLES; i++) begin
        if (hit_ev[i]) begin
          step = bcd_step(mole_score_q[i*W +: W], 4'd1);
          mole_score_d[i*W +: W] = step[W-1:0];
          score_ovf_d = score_ovf_d | step[W];
        end
        if (rise_ev[i]) begin
          step = bcd_step(mole_rise_q[i*W +: W], 4'd1);
          mole_rise_d[i*W +: W] = step[W-1:0];
          rise_ovf_d = rise_ovf_d | step[W];
        end
      end
      step          = bcd_step(total_score_q, popcount(hit_ev));
      total_score_d = step[W-1:0];
      score_ovf_d   = score_ovf_d | step[W];
      step          = bcd_step(total_rise_q, popcount(rise_ev));
      total_rise_d  = step[W-1:0];
      rise_ovf_d    = rise_ovf_d | step[W];
    end
  end

  // Counter and flag registers. The outputs are taken directly from these registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mole_score_q  <= '0;
      mole_rise_q   <= '0;
      total_score_q <= '0;
      total_rise_q  <= '0;
      score_ovf_q   <= 1'b0;
      rise_ovf_q    <= 1'b0;
    end else begin
      mole_score_q  <= mole_score_d;
      mole_rise_q   <= mole_rise_d;
      total_score_q <= total_score_d;
      total_rise_q  <= total_rise_d;
      score_ovf_q   <= score_ovf_d;
      rise_ovf_q    <= rise_ovf_d;
    end
  end

  assign bus.moleScore  = mole_score_q;
  assign bus.moleRise   = mole_rise_q;
  assign bus.totalScore = total_score_q;
  assign bus.totalRise  = total_rise_q;
  assign bus.scoreOvf   = score_ovf_q;
  assign bus.riseOvf    = rise_ovf_q;
endmodule

// File: tb/tb_mole_tally_bcd.sv
// Directed bench for mole_tally_bcd.
// The main instance uses the defaults (8 moles, 4 digits, saturate).
// Two 2-digit instances, one saturating and one wrapping, cover overflow.
module tb_mole_tally_bcd;
  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  mole_tally_bcd_if #(.NUM_MOLES(8), .DIGITS(4)) if_main ();
  mole_tally_bcd_if #(.NUM_MOLES(8), .DIGITS(2)) if_sat ();
  mole_tally_bcd_if #(.NUM_MOLES(8), .DIGITS(2)) if_wrap ();

  mole_tally_bcd #(.NUM_MOLES(8), .DIGITS(4), .SATURATE(1'b1)) u_main (
    .clock(clock), .reset(reset), .bus(if_main)
  );
  mole_tally_bcd #(.NUM_MOLES(8), .DIGITS(2), .SATURATE(1'b1)) u_sat (
    .clock(clock), .reset(reset), .bus(if_sat)
  );
  mole_tally_bcd #(.NUM_MOLES(8), .DIGITS(2), .SATURATE(1'b0)) u_wrap (
    .clock(clock), .reset(reset), .bus(if_wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_hit(input logic [7:0] m);
    if_main.hiding = 8'h00;
    tick();
    if_main.hiding = m;
    tick();
  endtask

  task automatic pulse_rise(input logic [7:0] m);
    if_main.rise = 8'h00;
    tick();
    if_main.rise = m;
    tick();
  endtask

  task automatic pulse_hit_small(input logic [7:0] m);
    if_sat.hiding  = 8'h00;
    if_wrap.hiding = 8'h00;
    tick();
    if_sat.hiding  = m;
    if_wrap.hiding = m;
    tick();
  endtask

  task automatic clear_main();
    if_main.clear = 1'b1;
    tick();
    if_main.clear = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (if_main.totalScore !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_total_score: got %h expected 0000", if_main.totalScore);
    end
    n_checks++;
    if (if_main.moleScore !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_mole_score: got %h expected 0", if_main.moleScore);
    end
    n_checks++;
    if (if_main.scoreOvf !== 1'b0 || if_main.riseOvf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b%b expected 00", if_main.scoreOvf, if_main.riseOvf);
    end
    #2 reset = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (if_main.totalScore !== 16'h0000 || if_main.moleScore !== 128'h0) begin
      n_fail++;
      $display("FAIL held_after_release: got %h %h expected 0", if_main.totalScore, if_main.moleScore);
    end
    if_main.hiding = 8'h00;
    tick();
    if_main.hiding = 8'hFF;
    #1;
    n_checks++;
    if (if_main.totalScore !== 16'h0000) begin
      n_fail++;
      $display("FAIL rise_latency: got %h expected 0000 before edge", if_main.totalScore);
    end
    tick();
    n_checks++;
    if (if_main.totalScore !== 16'h0008) begin
      n_fail++;
      $display("FAIL first_event_total: got %h expected 0008", if_main.totalScore);
    end
    n_checks++;
    if (if_main.moleScore !== {8{16'h0001}}) begin
      n_fail++;
      $display("FAIL first_event_mole: got %h expected all 0001", if_main.moleScore);
    end
  endtask

  task automatic test_bcd_carry();
    logic [127:0] exp_ms;
    clear_main();
    if_main.control = 8'h08;
    for (int i = 0; i < 109; i++) pulse_hit(8'hFF);
    exp_ms = '0;
    exp_ms[63:48] = 16'h0109;
    n_checks++;
    if (if_main.moleScore !== exp_ms) begin
      n_fail++;
      $display("FAIL bcd_mole3: got %h expected %h", if_main.moleScore, exp_ms);
    end
    n_checks++;
    if (if_main.totalScore !== 16'h0109) begin
      n_fail++;
      $display("FAIL bcd_total: got %h expected 0109", if_main.totalScore);
    end
    n_checks++;
    if (if_main.totalRise !== 16'h0000) begin
      n_fail++;
      $display("FAIL bcd_rise_untouched: got %h expected 0000", if_main.totalRise);
    end
  endtask

  task automatic test_simultaneous();
    if_main.control = 8'hFF;
    if_main.hiding  = 8'h00;
    if_main.rise    = 8'h00;
    clear_main();
    for (int i = 0; i < 13; i++) pulse_rise(8'hFF);
    n_checks++;
    if (if_main.totalRise !== 16'h0104) begin
      n_fail++;
      $display("FAIL simul_total_rise: got %h expected 0104", if_main.totalRise);
    end
    n_checks++;
    if (if_main.moleRise !== {8{16'h0013}}) begin
      n_fail++;
      $display("FAIL simul_mole_rise: got %h expected all 0013", if_main.moleRise);
    end
    n_checks++;
    if (if_main.riseOvf !== 1'b0 || if_main.totalScore !== 16'h0000) begin
      n_fail++;
      $display("FAIL simul_ovf_score: got %b %h expected 0 0000", if_main.riseOvf, if_main.totalScore);
    end
  endtask

  task automatic test_enable_clear();
    if_main.enable = 1'b0;
    for (int i = 0; i < 3; i++) pulse_rise(8'hFF);
    n_checks++;
    if (if_main.totalRise !== 16'h0104 || if_main.moleRise !== {8{16'h0013}}) begin
      n_fail++;
      $display("FAIL disabled_hold: got %h expected 0104", if_main.totalRise);
    end
    if_main.enable = 1'b1;
    tick();
    n_checks++;
    if (if_main.totalRise !== 16'h0104) begin
      n_fail++;
      $display("FAIL not_queued: got %h expected 0104", if_main.totalRise);
    end
    if_main.rise = 8'h00;
    tick();
    if_main.rise  = 8'hFF;
    if_main.clear = 1'b1;
    tick();
    if_main.clear = 1'b0;
    n_checks++;
    if (if_main.totalRise !== 16'h0000 || if_main.moleRise !== 128'h0 || if_main.riseOvf !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_priority: got %h %h expected 0", if_main.totalRise, if_main.moleRise);
    end
    tick();
    n_checks++;
    if (if_main.totalRise !== 16'h0000) begin
      n_fail++;
      $display("FAIL clear_dropped_event: got %h expected 0000", if_main.totalRise);
    end
  endtask

  task automatic test_independent();
    if_main.hiding = 8'h00;
    if_main.rise   = 8'h00;
    clear_main();
    tick();
    if_main.hiding = 8'h01;
    if_main.rise   = 8'h01;
    tick();
    n_checks++;
    if (if_main.totalScore !== 16'h0001 || if_main.totalRise !== 16'h0001) begin
      n_fail++;
      $display("FAIL both_events: got %h %h expected 0001 0001", if_main.totalScore, if_main.totalRise);
    end
    n_checks++;
    if (if_main.moleScore !== 128'h1 || if_main.moleRise !== 128'h1) begin
      n_fail++;
      $display("FAIL both_events_mole: got %h %h expected 1 1", if_main.moleScore, if_main.moleRise);
    end
  endtask

  task automatic test_async_reset();
    if_main.hiding = 8'h00;
    if_main.rise   = 8'h00;
    clear_main();
    for (int i = 0; i < 5; i++) pulse_hit(8'hFF);
    pulse_hit(8'h03);
    n_checks++;
    if (if_main.totalScore !== 16'h0042) begin
      n_fail++;
      $display("FAIL pre_reset_total: got %h expected 0042", if_main.totalScore);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (if_main.totalScore !== 16'h0000 || if_main.moleScore !== 128'h0) begin
      n_fail++;
      $display("FAIL async_reset: got %h %h expected 0", if_main.totalScore, if_main.moleScore);
    end
    #1 reset = 1'b1;
    tick();
  endtask

  task automatic test_saturate_wrap();
    if_sat.clear  = 1'b1;
    if_wrap.clear = 1'b1;
    if_sat.control  = 8'hFF;
    if_wrap.control = 8'hFF;
    if_sat.hiding   = 8'h00;
    if_wrap.hiding  = 8'h00;
    tick();
    if_sat.clear  = 1'b0;
    if_wrap.clear = 1'b0;
    for (int i = 0; i < 12; i++) pulse_hit_small(8'hFF);
    pulse_hit_small(8'h01);
    n_checks++;
    if (if_sat.totalScore !== 8'h97 || if_wrap.totalScore !== 8'h97) begin
      n_fail++;
      $display("FAIL pre_ovf_total: got %h %h expected 97", if_sat.totalScore, if_wrap.totalScore);
    end
    pulse_hit_small(8'hFF);
    n_checks++;
    if (if_sat.totalScore !== 8'h99 || if_sat.scoreOvf !== 1'b1) begin
      n_fail++;
      $display("FAIL saturate: got %h ovf %b expected 99 ovf 1", if_sat.totalScore, if_sat.scoreOvf);
    end
    n_checks++;
    if (if_wrap.totalScore !== 8'h05 || if_wrap.scoreOvf !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap: got %h ovf %b expected 05 ovf 1", if_wrap.totalScore, if_wrap.scoreOvf);
    end
    pulse_hit_small(8'h01);
    n_checks++;
    if (if_sat.totalScore !== 8'h99 || if_sat.scoreOvf !== 1'b1) begin
      n_fail++;
      $display("FAIL saturate_hold: got %h ovf %b expected 99 ovf 1", if_sat.totalScore, if_sat.scoreOvf);
    end
    n_checks++;
    if (if_wrap.totalScore !== 8'h06 || if_wrap.scoreOvf !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_continue: got %h ovf %b expected 06 ovf 1", if_wrap.totalScore, if_wrap.scoreOvf);
    end
    if_sat.clear = 1'b1;
    tick();
    if_sat.clear = 1'b0;
    n_checks++;
    if (if_sat.totalScore !== 8'h00 || if_sat.scoreOvf !== 1'b0 || if_sat.moleScore !== 128'h0) begin
      n_fail++;
      $display("FAIL clear_flags: got %h ovf %b expected 00 ovf 0", if_sat.totalScore, if_sat.scoreOvf);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    if_main.clear   = 1'b0;
    if_main.enable  = 1'b1;
    if_main.control = 8'hFF;
    if_main.hiding  = 8'hFF;
    if_main.rise    = 8'h00;
    if_sat.clear    = 1'b0;
    if_sat.enable   = 1'b1;
    if_sat.control  = 8'h00;
    if_sat.hiding   = 8'h00;
    if_sat.rise     = 8'h00;
    if_wrap.clear   = 1'b0;
    if_wrap.enable  = 1'b1;
    if_wrap.control = 8'h00;
    if_wrap.hiding  = 8'h00;
    if_wrap.rise    = 8'h00;
    repeat (2) tick();
    test_reset();
    test_bcd_carry();
    test_simultaneous();
    test_enable_clear();
    test_independent();
    test_async_reset();
    test_saturate_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mole_tally_bcd.md
Name: mole_tally_bcd

Overview:
- Parametrised successor to the per-mole score/rise counters and the chained decimal adder tree.
- Counts hits (control AND hiding) and rises (control AND rise) per mole as rising-edge events, synchronous to one clock.
- Keeps per-mole BCD counts plus running BCD totals, updated incrementally by event popcount, with saturate-or-wrap mode and sticky overflow.
- Sits between the mole FSM array and the score display/HEX decoders.

Parameters:
- NUM_MOLES, 8, number of mole channels; legal range 1..9, so the per-cycle popcount fits one BCD digit.
- DIGITS, 4, BCD digits per counter; legal range 1..6.
- SATURATE, 1, 1 = counters stick at all-9s; 0 = counters wrap to 0.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of all counts and flags.
- enable  in  1  game running; events are counted only while high.
- control  in  NUM_MOLES  per-mole active/go.
- hiding  in  NUM_MOLES  per-mole hiding status, from the mole FSM.
- rise  in  NUM_MOLES  per-mole rise status.
- moleScore  out  NUM_MOLES*DIGITS*4  per-mole hit counts, packed; mole i in slice [i*DIGITS*4 +: DIGITS*4].
- moleRise  out  NUM_MOLES*DIGITS*4  per-mole rise counts, packed the same way.
- totalScore  out  DIGITS*4  sum of hit events; BCD, least significant digit in bits [3:0].
- totalRise  out  DIGITS*4  sum of rise events; same BCD format.
- scoreOvf  out  1  sticky: totalScore or any per-mole hit count exceeded its maximum.
- riseOvf  out  1  sticky: totalRise or any per-mole rise count exceeded its maximum.

Behaviour:
- Per mole i:
  - hitCond[i] = control[i] & hiding[i].
  - riseCond[i] = control[i] & rise[i].
  - Registered copies hitPrev and risePrev.
  - hitEv[i] = hitCond[i] & ~hitPrev[i]; riseEv[i] likewise.
- The prev registers update every cycle, regardless of enable or clear. They reset to all-ones, so a condition already high at reset release produces no event.
- Latency: an event detected at clock edge k is visible on the count outputs after edge k. That is one cycle from the first sample of the condition high.
- Counters (per-mole and totals) are BCD. Every digit stays in 0..9 at all times; the max value is 10^DIGITS-1.
- Per-mole counter:
  - Increments by 1 on its event when enable=1.
  - Increment uses ripple carry across digits: 9 rolls to 0 and carries into the next digit.
- Total counter:
  - Adds popcount(hitEv) (or popcount(riseEv)) in one cycle, using a one-digit BCD add with carry ripple. It must not depend on the per-mole counters.
  - Multiple simultaneous events on different moles are all counted.
- Overflow (per-mole or total), when the increment would exceed the max:
  - SATURATE=1: the counter becomes the max (all 9s).
  - SATURATE=0: the counter becomes (value+inc) mod 10^DIGITS.
  - In both modes the matching sticky flag is set on the same edge.
  - Once saturated, further events leave the value unchanged and the flag stays 1.
- Priority, highest first:
  1. reset low: asynchronous; all counts 0, flags 0, prev all-ones.
  2. clear=1: all counts 0, flags 0; events in that cycle are dropped.
  3. enable=0: counts hold; events are dropped, not queued.
  4. Count the events.
- Reset asserted mid-count: outputs go to 0 immediately, without waiting for a clock edge.
- After reset release, a condition that stays high is not counted until it falls and rises again.
- A condition held high for N cycles is one event. A condition toggling every cycle gives one event per 0→1 transition.
- Outputs are driven directly from registers. There is no combinational path from inputs to outputs.
- The hit and rise paths are fully independent. The same mole may produce both events in one cycle.

Test Plan:
- Reset and edge behaviour:
  - Stimulus: hold reset low with control=hiding=8'hFF, release, hold for 5 cycles.
  - Response: all outputs 0, scoreOvf=0, and no count after release.
  - Then drop hiding for 1 cycle and raise it: totalScore=16'h0008, each moleScore digit = 1, visible one cycle after the rise.
- BCD carry:
  - Stimulus: 109 single hit events on mole 3.
  - Response: mole 3 slice = 16'h0109, totalScore=16'h0109, other moles 0.
- Simultaneous events:
  - Stimulus: all 8 moles rise in the same cycle, 13 times.
  - Response: totalRise=16'h0104, each moleRise = 16'h0013, riseOvf=0.
- Saturate vs wrap:
  - Stimulus: DIGITS=2; drive total to 16'h97, then 8 simultaneous hits.
  - Response with SATURATE=1: totalScore=8'h99, scoreOvf=1; a further event keeps 8'h99.
  - Response with SATURATE=0: totalScore=8'h05, scoreOvf=1.
- Enable and clear priority:
  - Stimulus: enable=0 with 3 events.
  - Response: counts unchanged.
  - Stimulus: clear=1 in the same cycle as an event.
  - Response: all counts 0 and flags 0 on the next cycle.
- Asynchronous reset mid-run:
  - Stimulus: with totals at 16'h0042, pulse reset low between clock edges.
  - Response: outputs read 0 before the next clock edge.
